// File: rtl/i2c_pad_filter.sv
// rtl/i2c_pad_filter.sv - SCL/SDA pad synchroniser, glitch filter, START/STOP detect, stuck-low monitor
module i2c_pad_filter #(
    parameter int FILT_W = 4,
    parameter int TOUT_W = 20
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic              tout_en_i,
    input  logic [TOUT_W-1:0] tout_lim_i,
    input  logic              stuck_clr_i,
    input  logic              scl_pad_i,
    input  logic              sda_pad_i,
    output logic              scl_o,
    output logic              sda_o,
    output logic              start_det_o,
    output logic              stop_det_o,
    output logic              bus_busy_o,
    output logic              scl_stuck_o,
    output logic              sda_stuck_o
);

    localparam int SCL = 0;
    localparam int SDA = 1;

    logic [1:0]        sync1_q;
    logic [1:0]        sync2_q;
    logic [1:0]        line_q,   line_d;
    logic [1:0]        prev_q;
    logic [FILT_W-1:0] fcnt_q [2];
    logic [FILT_W-1:0] fcnt_d [2];
    logic [TOUT_W-1:0] scnt_q [2];
    logic [TOUT_W-1:0] scnt_d [2];
    logic [1:0]        stuck_q,  stuck_d;
    logic              start_q,  start_d;
    logic              stop_q,   stop_d;
    logic              busy_q,   busy_d;
    logic [FILT_W-1:0] filt_last;

    // A length of 0 is treated as 1, so the terminal count is never below zero.
    assign filt_last = (filt_len_i == '0) ? '0 : (filt_len_i - FILT_W'(1));

    always_comb begin
        line_d = line_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == line_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] >= filt_last) begin
                line_d[i] = sync2_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + FILT_W'(1);
            end
        end
    end

    // Stuck counters watch the filtered lines; clear beats set.
    always_comb begin
        stuck_d = stuck_q;
        scnt_d  = scnt_q;
        for (int i = 0; i < 2; i++) begin
            if (stuck_clr_i) begin
                stuck_d[i] = 1'b0;
                scnt_d[i]  = '0;
            end else begin
                if ((tout_lim_i != '0) && (scnt_q[i] >= tout_lim_i)) begin
                    stuck_d[i] = 1'b1;
                end
                if (!line_q[i] && tout_en_i) begin
                    scnt_d[i] = (scnt_q[i] == '1) ? scnt_q[i] : (scnt_q[i] + TOUT_W'(1));
                end else begin
                    scnt_d[i] = '0;
                end
            end
        end
    end

    always_comb begin
        start_d = prev_q[SDA] & ~line_q[SDA] & prev_q[SCL] & line_q[SCL];
        stop_d  = ~prev_q[SDA] & line_q[SDA] & prev_q[SCL] & line_q[SCL];
        busy_d  = busy_q;
        if (start_d) begin
            busy_d = 1'b1;
        end else if (stop_d) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            line_q  <= 2'b11;
            prev_q  <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                fcnt_q[i] <= '0;
                scnt_q[i] <= '0;
            end
            stuck_q <= 2'b00;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= {sda_pad_i, scl_pad_i};
            sync2_q <= sync1_q;
            line_q  <= line_d;
            prev_q  <= line_q;
            for (int i = 0; i < 2; i++) begin
                fcnt_q[i] <= fcnt_d[i];
                scnt_q[i] <= scnt_d[i];
            end
            stuck_q <= stuck_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            busy_q  <= busy_d;
        end
    end

    assign scl_o       = line_q[SCL];
    assign sda_o       = line_q[SDA];
    assign start_det_o = start_q;
    assign stop_det_o  = stop_q;
    assign bus_busy_o  = busy_q;
    assign scl_stuck_o = stuck_q[SCL];
    assign sda_stuck_o = stuck_q[SDA];

endmodule

// File: tb/tb_i2c_pad_filter.sv
// tb/tb_i2c_pad_filter.sv - randomized and directed checks of i2c_pad_filter against a behavioural model
module tb_i2c_pad_filter;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [3:0]  filt_len_i = 4'd0;
    logic        tout_en_i = 1'b0;
    logic [19:0] tout_lim_i = 20'd0;
    logic        stuck_clr_i = 1'b0;
    logic        scl_pad_i = 1'b1;
    logic        sda_pad_i = 1'b1;
    logic        scl_o, sda_o, start_det_o, stop_det_o, bus_busy_o, scl_stuck_o, sda_stuck_o;

    int errors = 0;
    int checks = 0;
    int n_start = 0;
    int n_stop = 0;

    i2c_pad_filter #(.FILT_W(4), .TOUT_W(20)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .filt_len_i(filt_len_i), .tout_en_i(tout_en_i),
        .tout_lim_i(tout_lim_i), .stuck_clr_i(stuck_clr_i), .scl_pad_i(scl_pad_i),
        .sda_pad_i(sda_pad_i), .scl_o(scl_o), .sda_o(sda_o), .start_det_o(start_det_o),
        .stop_det_o(stop_det_o), .bus_busy_o(bus_busy_o), .scl_stuck_o(scl_stuck_o),
        .sda_stuck_o(sda_stuck_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pads reach the filter two samples late; the output flips once the
    // differing level has persisted for L consecutive samples.
    bit m_p1 [2];
    bit m_p2 [2];
    bit m_out [2];
    bit m_prev [2];
    int m_run [2];
    int m_low [2];
    bit m_stk [2];
    bit m_start, m_stop, m_busy;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 2; i++) begin
                m_p1[i] = 1; m_p2[i] = 1; m_out[i] = 1; m_prev[i] = 1;
                m_run[i] = 0; m_low[i] = 0; m_stk[i] = 0;
            end
            m_start = 0; m_stop = 0; m_busy = 0;
        end else begin
            bit pad [2];
            bit st, sp;
            int len, lim;
            pad[0] = scl_pad_i;
            pad[1] = sda_pad_i;
            len = (filt_len_i == 0) ? 1 : int'(filt_len_i);
            lim = int'(tout_lim_i);
            st = m_prev[1] && !m_out[1] && m_prev[0] && m_out[0];
            sp = !m_prev[1] && m_out[1] && m_prev[0] && m_out[0];
            for (int i = 0; i < 2; i++) begin
                if (stuck_clr_i) begin
                    m_stk[i] = 0;
                    m_low[i] = 0;
                end else begin
                    if (lim != 0 && m_low[i] >= lim) m_stk[i] = 1;
                    if (!m_out[i] && tout_en_i) m_low[i] = (m_low[i] < 20'hFFFFF) ? m_low[i] + 1 : m_low[i];
                    else m_low[i] = 0;
                end
                m_prev[i] = m_out[i];
                if (m_p2[i] == m_out[i]) begin
                    m_run[i] = 0;
                end else if (m_run[i] + 1 >= len) begin
                    m_out[i] = m_p2[i];
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                end
                m_p2[i] = m_p1[i];
                m_p1[i] = pad[i];
            end
            m_start = st;
            m_stop = sp;
            if (st) m_busy = 1;
            else if (sp) m_busy = 0;
        end
    end

    always @(negedge HCLK) begin
        check("scl_o", int'(scl_o), int'(m_out[0]));
        check("sda_o", int'(sda_o), int'(m_out[1]));
        check("start_det_o", int'(start_det_o), int'(m_start));
        check("stop_det_o", int'(stop_det_o), int'(m_stop));
        check("bus_busy_o", int'(bus_busy_o), int'(m_busy));
        check("scl_stuck_o", int'(scl_stuck_o), int'(m_stk[0]));
        check("sda_stuck_o", int'(sda_stuck_o), int'(m_stk[1]));
        if (start_det_o) n_start++;
        if (stop_det_o) n_stop++;
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge HCLK);
    endtask

    initial begin
        int k, s0, p0;
        bit saw_low;

        wait_cycles(3);
        check("reset scl_o", int'(scl_o), 1);
        check("reset sda_o", int'(sda_o), 1);
        check("reset bus_busy_o", int'(bus_busy_o), 0);
        check("reset scl_stuck_o", int'(scl_stuck_o), 0);
        HRESETn = 1'b1;
        filt_len_i = 4'd3;
        wait_cycles(5);

        // Two-cycle SDA glitch with L=3 must be rejected
        s0 = n_start;
        sda_pad_i = 1'b0;
        wait_cycles(2);
        sda_pad_i = 1'b1;
        saw_low = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge HCLK); #1;
            if (!sda_o) saw_low = 1;
        end
        check("glitch sda_o low", int'(saw_low), 0);
        check("glitch start count", n_start - s0, 0);
        check("glitch busy", int'(bus_busy_o), 0);

        // Real START: sda_o falls on the 5th edge, start pulses the next cycle
        @(negedge HCLK);
        sda_pad_i = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge HCLK); #1;
            k++;
            if (!sda_o) break;
        end
        check("start latency edges", k, 5);
        check("start before pulse", int'(start_det_o), 0);
        @(posedge HCLK); #1;
        check("start pulse", int'(start_det_o), 1);
        check("busy after start", int'(bus_busy_o), 1);
        @(posedge HCLK); #1;
        check("start pulse width", int'(start_det_o), 0);

        // Repeated START then STOP, L=0 behaves as 1
        @(negedge HCLK);
        filt_len_i = 4'd0;
        s0 = n_start; p0 = n_stop;
        scl_pad_i = 1'b0; wait_cycles(6);
        sda_pad_i = 1'b1; wait_cycles(6);
        scl_pad_i = 1'b1; wait_cycles(6);
        check("busy before rstart", int'(bus_busy_o), 1);
        sda_pad_i = 1'b0; wait_cycles(6);
        check("rstart count", n_start - s0, 1);
        check("busy after rstart", int'(bus_busy_o), 1);
        sda_pad_i = 1'b1; wait_cycles(6);
        check("stop count", n_stop - p0, 1);
        check("busy after stop", int'(bus_busy_o), 0);

        // Simultaneous SCL/SDA changes are not START/STOP
        s0 = n_start; p0 = n_stop;
        scl_pad_i = 1'b0; sda_pad_i = 1'b0; wait_cycles(6);
        scl_pad_i = 1'b1; sda_pad_i = 1'b1; wait_cycles(6);
        check("simul start count", n_start - s0, 0);
        check("simul stop count", n_stop - p0, 0);
        check("simul busy", int'(bus_busy_o), 0);

        // Stuck-low timeout on SCL with limit 10
        tout_en_i = 1'b1;
        tout_lim_i = 20'd10;
        scl_pad_i = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge HCLK); #1;
            k++;
            if (!scl_o) break;
        end
        check("scl filter latency L=1", k, 3);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge HCLK); #1;
            k++;
            if (scl_stuck_o) break;
        end
        check("stuck edges", k, 11);
        @(negedge HCLK);
        stuck_clr_i = 1'b1;
        @(posedge HCLK); #1;
        check("stuck cleared", int'(scl_stuck_o), 0);
        @(negedge HCLK);
        stuck_clr_i = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge HCLK); #1;
            k++;
            if (scl_stuck_o) break;
        end
        check("restuck edges", k, 12 - 1);
        @(negedge HCLK);
        scl_pad_i = 1'b1; wait_cycles(5);
        check("stuck sticky", int'(scl_stuck_o), 1);
        stuck_clr_i = 1'b1; wait_cycles(1);
        stuck_clr_i = 1'b0;
        scl_pad_i = 1'b0; wait_cycles(8);
        scl_pad_i = 1'b1; wait_cycles(20);
        check("short low no stuck", int'(scl_stuck_o), 0);

        // Randomized traffic against the model
        begin
            int hold_scl, hold_sda;
            hold_scl = 1; hold_sda = 1;
            for (int c = 0; c < 4000; c++) begin
                @(negedge HCLK);
                if (c % 250 == 0) begin
                    filt_len_i = 4'($urandom_range(0, 5));
                    tout_lim_i = 20'($urandom_range(0, 15));
                    tout_en_i = 1'($urandom_range(0, 3) != 0);
                end
                stuck_clr_i = 1'($urandom_range(0, 60) == 0);
                if (--hold_scl == 0) begin
                    scl_pad_i = ~scl_pad_i;
                    hold_scl = $urandom_range(1, 12);
                end
                if (--hold_sda == 0) begin
                    sda_pad_i = ~sda_pad_i;
                    hold_sda = $urandom_range(1, 12);
                end
            end
        end

        // Async reset mid-transfer
        @(negedge HCLK);
        stuck_clr_i = 1'b0;
        filt_len_i = 4'd1; tout_en_i = 1'b1; tout_lim_i = 20'd100;
        scl_pad_i = 1'b1; sda_pad_i = 1'b1; wait_cycles(8);
        sda_pad_i = 1'b0; wait_cycles(6);
        scl_pad_i = 1'b0; wait_cycles(4);
        check("busy before reset", int'(bus_busy_o), 1);
        #2 HRESETn = 1'b0;
        #1;
        check("async rst scl_o", int'(scl_o), 1);
        check("async rst sda_o", int'(sda_o), 1);
        check("async rst busy", int'(bus_busy_o), 0);
        check("async rst start", int'(start_det_o), 0);
        check("async rst stop", int'(stop_det_o), 0);
        check("async rst scl_stuck", int'(scl_stuck_o), 0);
        check("async rst sda_stuck", int'(sda_stuck_o), 0);
        scl_pad_i = 1'b1; sda_pad_i = 1'b1;
        wait_cycles(3);
        HRESETn = 1'b1;
        s0 = n_start; p0 = n_stop;
        wait_cycles(10);
        check("post reset start", n_start - s0, 0);
        check("post reset stop", n_stop - p0, 0);
        check("post reset busy", int'(bus_busy_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
